// File: rtl/reset_pkg.sv
// reset_pkg: types shared by the reset sequencer files.
//   state_e : sequencer states IDLE / ARMED / FLUSH / RESET
//   cause_e : latched reset cause. The encoding doubles as the request
//             priority (wdt > btn > sw), so causes compare with '>'.
package reset_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FLUSH = 2'd2,
        RESET = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_SW   = 2'd1,
        CAUSE_BTN  = 2'd2,
        CAUSE_WDT  = 2'd3
    } cause_e;

    // Highest-priority request raised this cycle, CAUSE_NONE if none.
    function automatic cause_e highest_req(input logic wdt, input logic btn, input logic sw);
        if (wdt)      return CAUSE_WDT;
        else if (btn) return CAUSE_BTN;
        else if (sw)  return CAUSE_SW;
        else          return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: control/handshake bundle of the reset sequencer.
//   sw_req    : single-cycle software reset request
//   sw_cancel : single-cycle cancel (only honoured while ARMED)
//   wdt_en    : watchdog enable level (watchdog build only)
//   wdt_kick  : single-cycle watchdog service (watchdog build only)
//   flush_ack : downstream has quiesced (level)
//   flush_req : asks downstream storage/USB logic to quiesce
//   pending   : a reset sequence is in progress
//   cause     : 0 none, 1 sw, 2 btn, 3 wdt
// master = SoC / board side, slave = the sequencer.
interface reset_sequencer_if;
    logic       sw_req;
    logic       sw_cancel;
    logic       wdt_en;
    logic       wdt_kick;
    logic       flush_ack;
    logic       flush_req;
    logic       pending;
    logic [1:0] cause;

    modport master (
        output sw_req, sw_cancel, wdt_en, wdt_kick, flush_ack,
        input  flush_req, pending, cause
    );

    modport slave (
        input  sw_req, sw_cancel, wdt_en, wdt_kick, flush_ack,
        output flush_req, pending, cause
    );
endinterface

// File: rtl/btn_longpress.sv
// btn_longpress: long-press detector for the active-low user button.
//   clk, rst   : system clock, async active-high reset
//   i_btn_n    : raw button, active-low, asynchronous to clk
//   o_hit      : one-cycle pulse when the button has been held for
//                HOLD_CYCLES synchronised cycles
// The hold counter saturates at HOLD_CYCLES, so holding the button longer
// never produces a second pulse; releasing it clears the counter.
module btn_longpress #(
    parameter int HOLD_CYCLES = 48000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_n,
    output logic o_hit
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD = CW'(HOLD_CYCLES);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b11;    // released
            r_cnt  <= '0;
            r_hit  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn_n};
            r_hit  <= 1'b0;
            if (r_sync[1]) begin
                r_cnt <= '0;
            end else if (r_cnt != HOLD) begin
                r_cnt <= r_cnt + 1'b1;
                // pulse on the same edge the counter lands on HOLD
                r_hit <= (r_cnt == HOLD - 1'b1);
            end
        end
    end

    assign o_hit = r_hit;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: arbitrates board-reset requests and drives the
// OrangeCrab self-reset pin.
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   btn_n      : raw user button, active-low (long press requests reset)
//   nreset_out : board reset pin, active-low, registered
//   bus        : reset_sequencer_if.slave (sw_req/sw_cancel/wdt_en/
//                wdt_kick/flush_ack in, flush_req/pending/cause out)
// Sequence: IDLE -> ARMED (cancellable grace) -> FLUSH (wait for ack or
// timeout) -> RESET (pin low, terminal until rst).
// Build option: define RESET_SEQUENCER_WDT_EN to include the watchdog;
// without it wdt_en/wdt_kick are ignored and cause never reaches 3.
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int GRACE_CYCLES    = 1024,
    parameter int BTN_HOLD_CYCLES = 48000000,
    parameter int FLUSH_TIMEOUT   = 4096,
    parameter int WDT_CYCLES      = 16777216
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_n,
    output logic             nreset_out,
    reset_sequencer_if.slave bus
);
    localparam int GW = $clog2(GRACE_CYCLES + 1);
    localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
    // Counters are loaded with N-1 and the transition fires on the cycle
    // they read 0, giving exactly N cycles in the state.
    localparam logic [GW-1:0] GRACE_LOAD = GW'(GRACE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LOAD   = TW'(FLUSH_TIMEOUT - 1);

    state_e        r_state, w_state_nxt;
    cause_e        r_cause, w_cause_nxt;
    logic [GW-1:0] r_grace, w_grace_nxt;
    logic [TW-1:0] r_tmo,   w_tmo_nxt;
    logic          r_flush_req;
    logic          r_pending;
    logic          r_nreset;
    logic          w_btn_hit;
    logic          w_wdt_req;
    cause_e        w_req;

    btn_longpress #(
        .HOLD_CYCLES (BTN_HOLD_CYCLES)
    ) u_btn (
        .clk     (clk),
        .rst     (rst),
        .i_btn_n (btn_n),
        .o_hit   (w_btn_hit)
    );

`ifdef RESET_SEQUENCER_WDT_EN
    localparam int WW = $clog2(WDT_CYCLES + 1);
    localparam logic [WW-1:0] WDT_LOAD = WW'(WDT_CYCLES);

    logic [WW-1:0] r_wdt_cnt;
    logic          r_wdt_en_d;
    logic          r_wdt_hit;
    logic          w_wdt_frozen;

    assign w_wdt_frozen = (r_state == FLUSH) || (r_state == RESET);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdt_cnt  <= '0;
            r_wdt_en_d <= 1'b0;
            r_wdt_hit  <= 1'b0;
        end else begin
            r_wdt_en_d <= bus.wdt_en;
            r_wdt_hit  <= 1'b0;
            if (!w_wdt_frozen) begin
                if (bus.wdt_kick || (bus.wdt_en && !r_wdt_en_d)) begin
                    r_wdt_cnt <= WDT_LOAD;
                end else if (bus.wdt_en && (r_wdt_cnt != '0)) begin
                    r_wdt_cnt <= r_wdt_cnt - 1'b1;
                    // one request as the count reaches 0; it then sits at 0
                    r_wdt_hit <= (r_wdt_cnt == WW'(1));
                end
            end
        end
    end

    assign w_wdt_req = r_wdt_hit;
`else
    logic w_unused_wdt;
    assign w_unused_wdt = bus.wdt_en ^ bus.wdt_kick ^ (WDT_CYCLES == 0);
    assign w_wdt_req    = 1'b0;
`endif

    assign w_req = highest_req(w_wdt_req, w_btn_hit, bus.sw_req);

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        w_grace_nxt = r_grace;
        w_tmo_nxt   = r_tmo;
        case (r_state)
            IDLE: begin
                if (w_req != CAUSE_NONE) begin
                    w_state_nxt = ARMED;
                    w_cause_nxt = w_req;
                    w_grace_nxt = GRACE_LOAD;
                end
            end
            ARMED: begin
                // watchdog resets (latched or arriving now) are not cancellable
                if (bus.sw_cancel && (r_cause != CAUSE_WDT) && (w_req != CAUSE_WDT)) begin
                    w_state_nxt = IDLE;
                    w_cause_nxt = CAUSE_NONE;
                    w_grace_nxt = '0;
                end else if (w_req > r_cause) begin
                    w_cause_nxt = w_req;
                    w_grace_nxt = GRACE_LOAD;
                end else if (r_grace == '0) begin
                    w_state_nxt = FLUSH;
                    w_tmo_nxt   = TMO_LOAD;
                end else begin
                    w_grace_nxt = r_grace - 1'b1;
                end
            end
            FLUSH: begin
                if (bus.flush_ack || (r_tmo == '0)) begin
                    w_state_nxt = RESET;
                end else begin
                    w_tmo_nxt = r_tmo - 1'b1;
                end
            end
            RESET: begin
                w_state_nxt = RESET;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cause     <= CAUSE_NONE;
            r_grace     <= '0;
            r_tmo       <= '0;
            r_pending   <= 1'b0;
            r_flush_req <= 1'b0;
            r_nreset    <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cause     <= w_cause_nxt;
            r_grace     <= w_grace_nxt;
            r_tmo       <= w_tmo_nxt;
            r_pending   <= (w_state_nxt != IDLE);
            r_flush_req <= (w_state_nxt == FLUSH) || (w_state_nxt == RESET);
            r_nreset    <= (w_state_nxt != RESET);
        end
    end

    assign bus.pending   = r_pending;
    assign bus.flush_req = r_flush_req;
    assign bus.cause     = r_cause;
    assign nreset_out    = r_nreset;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scenarios plus randomized stimulus, checked
// every cycle against a deadline-based reference model of the sequencer.
module tb_reset_sequencer;
    localparam int G = 8;
    localparam int H = 16;
    localparam int T = 10;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_n = 1'b1;
    logic nreset_out;

    reset_sequencer_if bus();

    reset_sequencer #(
        .GRACE_CYCLES    (G),
        .BTN_HOLD_CYCLES (H),
        .FLUSH_TIMEOUT   (T),
        .WDT_CYCLES      (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_n      (btn_n),
        .nreset_out (nreset_out),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 armed, 2 flushing, 3 board in reset.
    // Grace and timeout are tracked as the absolute edge number at which
    // they expire rather than as down-counters.
    int m_ph = 0, m_cause = 0, m_cyc = 0;
    int m_flush_at = 0, m_reset_at = 0;
    int m_req = 0;
    int m_btn_run = 0;
    bit m_btn_hit = 0;
    logic m_raw1 = 1'b1, m_raw2 = 1'b1;   // raw button 1 and 2 edges ago
    logic m_syn;
    bit m_wdt_hit = 0;
    int m_wdt_left = 0;
    logic m_wdt_en_prev = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph = 0; m_cause = 0;
            m_btn_run = 0; m_btn_hit = 0;
            m_raw1 = 1'b1; m_raw2 = 1'b1;
            m_wdt_hit = 0; m_wdt_left = 0; m_wdt_en_prev = 1'b0;
        end else begin
            m_cyc++;
            m_req = m_wdt_hit ? 3 : (m_btn_hit ? 2 : (bus.sw_req ? 1 : 0));
`ifdef RESET_SEQUENCER_WDT_EN
            m_wdt_hit = 0;
            if (m_ph < 2) begin
                if (bus.wdt_kick || (bus.wdt_en && !m_wdt_en_prev)) m_wdt_left = W;
                else if (bus.wdt_en && m_wdt_left > 0) begin
                    m_wdt_left--;
                    m_wdt_hit = (m_wdt_left == 0);
                end
            end
            m_wdt_en_prev = bus.wdt_en;
`endif
            case (m_ph)
                0: if (m_req != 0) begin
                    m_ph = 1; m_cause = m_req; m_flush_at = m_cyc + G;
                end
                1: begin
                    if (bus.sw_cancel && m_cause != 3 && m_req != 3) begin
                        m_ph = 0; m_cause = 0;
                    end else if (m_req > m_cause) begin
                        m_cause = m_req; m_flush_at = m_cyc + G;
                    end else if (m_cyc == m_flush_at) begin
                        m_ph = 2; m_reset_at = m_cyc + T;
                    end
                end
                2: if (bus.flush_ack || m_cyc == m_reset_at) m_ph = 3;
                default: ;
            endcase
            // button: two-stage synchroniser, then run length of low samples
            m_syn = m_raw2;
            m_raw2 = m_raw1;
            m_raw1 = btn_n;
            if (m_syn == 1'b0) m_btn_run++; else m_btn_run = 0;
            m_btn_hit = (m_btn_run == H);
        end
    end

    always @(negedge clk) begin
        chk("pending",   32'(bus.pending),   32'(m_ph != 0));
        chk("cause",     32'(bus.cause),     32'(m_cause));
        chk("flush_req", 32'(bus.flush_req), 32'(m_ph >= 2));
        chk("nreset",    32'(nreset_out),    32'(m_ph != 3));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        bus.sw_req = 0; bus.sw_cancel = 0; bus.flush_ack = 0;
        bus.wdt_en = 0; bus.wdt_kick = 0; btn_n = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick(2);
        rst = 0;
        tick(1);
    endtask

    task automatic wait_pending(input string tag, input int budget);
        int n = 0;
        while (bus.pending !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.pending), 32'd1);
    endtask

    initial begin
        idle_inputs();
        do_reset();
        chk("rst_pending", 32'(bus.pending), 0);
        chk("rst_cause",   32'(bus.cause), 0);
        chk("rst_nreset",  32'(nreset_out), 1);
        chk("rst_flush",   32'(bus.flush_req), 0);

        // software request, ack three cycles into FLUSH
        bus.sw_req = 1; tick(); bus.sw_req = 0;
        chk("sw_pend_p1", 32'(bus.pending), 1);
        chk("sw_cause", 32'(bus.cause), 1);
        tick(7);
        chk("sw_flush_p8", 32'(bus.flush_req), 0);
        tick();
        chk("sw_flush_p9", 32'(bus.flush_req), 1);
        tick(2);
        bus.flush_ack = 1; tick(); bus.flush_ack = 0;
        chk("ack_nreset", 32'(nreset_out), 0);
        chk("ack_cause", 32'(bus.cause), 1);

        // cancel inside grace window
        do_reset();
        bus.sw_req = 1; tick(); bus.sw_req = 0;
        tick(3);
        bus.sw_cancel = 1; tick(); bus.sw_cancel = 0;
        chk("cancel_pend", 32'(bus.pending), 0);
        chk("cancel_cause", 32'(bus.cause), 0);
        tick(100);
        chk("cancel_nreset", 32'(nreset_out), 1);

        // short press, long press, no retrigger while held
        do_reset();
        btn_n = 0; tick(15); btn_n = 1;
        tick(30);
        chk("short_press", 32'(bus.pending), 0);
        btn_n = 0;
        wait_pending("long_press", 30);
        chk("btn_cause", 32'(bus.cause), 2);
        bus.sw_cancel = 1; tick(); bus.sw_cancel = 0;
        tick(40);
        chk("btn_noretrig", 32'(bus.pending), 0);
        btn_n = 1; tick(5); btn_n = 0;
        wait_pending("btn_repress", 30);
        chk("btn_cause2", 32'(bus.cause), 2);
        btn_n = 1;

        // sw_req coincident with btn_hit: button wins
        do_reset();
        btn_n = 0; tick(18);
        bus.sw_req = 1; tick(); bus.sw_req = 0;
        chk("sw_btn_tie", 32'(bus.cause), 2);
        btn_n = 1;

`ifdef RESET_SEQUENCER_WDT_EN
        // watchdog expiring during ARMED upgrades cause, reloads grace
        do_reset();
        bus.wdt_en = 1; tick(28);
        bus.sw_req = 1; tick(); bus.sw_req = 0;
        chk("wdt_pre", 32'(bus.cause), 1);
        tick(5);
        chk("wdt_cause", 32'(bus.cause), 3);
        tick();
        bus.sw_cancel = 1; tick(); bus.sw_cancel = 0;
        chk("wdt_nocancel", 32'(bus.pending), 1);
        tick();
        chk("wdt_reload", 32'(bus.flush_req), 0);
        tick(5);
        chk("wdt_flush", 32'(bus.flush_req), 1);
        bus.wdt_en = 0;
`else
        do_reset();
        bus.wdt_en = 1; tick(100);
        chk("nowdt_idle", 32'(bus.pending), 0);
        chk("nowdt_cause", 32'(bus.cause), 0);
        bus.wdt_en = 0;
`endif

        // flush timeout with no ack
        do_reset();
        bus.sw_req = 1; tick(); bus.sw_req = 0;
        tick(8);
        chk("tmo_flush", 32'(bus.flush_req), 1);
        tick(9);
        chk("tmo_p9", 32'(nreset_out), 1);
        tick();
        chk("tmo_p10", 32'(nreset_out), 0);

        // asynchronous reset out of RESET, no clock edge in between
        rst = 1; #1;
        chk("async_nreset", 32'(nreset_out), 1);
        chk("async_pending", 32'(bus.pending), 0);
        chk("async_flush", 32'(bus.flush_req), 0);
        tick(); rst = 0;

        // randomized episodes
        for (int ep = 0; ep < 30; ep++) begin
            do_reset();
            for (int c = 0; c < 200; c++) begin
                bus.sw_req    = ($urandom_range(15) == 0);
                bus.sw_cancel = ($urandom_range(11) == 0);
                bus.flush_ack = ($urandom_range(7) == 0);
                bus.wdt_kick  = ($urandom_range(19) == 0);
                if ($urandom_range(39) == 0) bus.wdt_en = ~bus.wdt_en;
                if ($urandom_range(23) == 0) btn_n = ~btn_n;
                rst = ($urandom_range(299) == 0);
                tick();
            end
            rst = 0;
        end

        idle_inputs();
        tick(2);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Arbitrates all board-reset requests and sequences the OrangeCrab self-reset pin.
- Request sources: software register pulse, long-press of the user button, and an optional watchdog.
- Gives the chosen request a cancellable grace period, then a flush handshake so the storage and USB logic can quiesce, then drives the active-low reset pin low permanently.
- Sits between the SoC control registers / board I/O and the FPGA pin that resets the board.

Parameters:
- GRACE_CYCLES, 1024: cycles spent in ARMED before the flush starts; software may cancel during this window; minimum 1.
- BTN_HOLD_CYCLES, 48000000: cycles the synchronised button must stay pressed to raise a request; minimum 1.
- FLUSH_TIMEOUT, 4096: maximum cycles to wait for flush_ack; minimum 1.
- WDT_CYCLES, 16777216: watchdog period in cycles; used only with the watchdog compiled in.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- sw_req  in  1  single-cycle software reset request
- sw_cancel  in  1  single-cycle cancel; honoured only in ARMED
- btn_n  in  1  raw user button, active-low, asynchronous to clk
- wdt_en  in  1  watchdog enable level (watchdog build only)
- wdt_kick  in  1  single-cycle watchdog service (watchdog build only)
- flush_req  out  1  asks downstream logic to quiesce
- flush_ack  in  1  downstream quiesced (level)
- pending  out  1  high in ARMED, FLUSH or RESET
- cause  out  2  0 none, 1 sw, 2 btn, 3 wdt
- nreset_out  out  1  board reset pin, active-low

Behaviour:
- Under rst: state IDLE, all counters cleared, nreset_out=1, flush_req=0, pending=0, cause=0.
- btn_n passes through a 2-flop synchroniser. The hold counter counts while the synchronised button is low and clears when it is high.
- btn_hit is a single-cycle pulse on the cycle the hold counter reaches BTN_HOLD_CYCLES. The counter then saturates; no re-trigger until the button is released.
- All counters are $clog2(limit+1) bits wide and saturate; none wrap.
- IDLE: on any request go to ARMED, load the grace counter and latch cause.
  - Simultaneous requests resolve by priority: wdt > btn > sw.
- ARMED:
  - Grace counter decrements each cycle; at 0 go to FLUSH.
  - sw_cancel → IDLE, cause=0.
  - sw_cancel is ignored if cause=3 (watchdog resets cannot be cancelled).
  - sw_cancel and sw_req in the same cycle: cancel wins.
  - A higher-priority request arriving in ARMED overwrites cause and reloads the grace counter. Equal- or lower-priority requests are ignored.
- FLUSH: flush_req=1 and the timeout counter decrements. Go to RESET on flush_ack=1 or when the counter reaches 0, whichever comes first. New requests and cancels are ignored.
- RESET: nreset_out=0, flush_req held at 1. Terminal state; only rst leaves it, and in practice the board loses power first.
- pending = (state != IDLE).
- All outputs are registered, so they change on the clock edge after the state change.
- Latencies:
  - sw_req to pending: 1 cycle.
  - ARMED to FLUSH: GRACE_CYCLES cycles.
  - flush_ack to nreset_out low: 1 cycle.
- rst asserted mid-sequence (including RESET) returns everything to reset values immediately.

Optional Feature:
- Macro: RESET_SEQUENCER_WDT_EN.
- Defined:
  - The watchdog counter counts down while wdt_en=1.
  - wdt_kick, or a rising edge of wdt_en, reloads it to WDT_CYCLES.
  - Reaching 0 while in IDLE or ARMED raises a wdt request.
  - The counter freezes once state is FLUSH or RESET.
- Not defined:
  - wdt_en and wdt_kick are present but ignored.
  - No watchdog logic is generated.
  - cause never equals 3.

Decomposition:
- Shared package reset_pkg holds:
  - the state enum IDLE/ARMED/FLUSH/RESET;
  - the cause encodings CAUSE_NONE/SW/BTN/WDT.
- One natural sub-module: btn_longpress, containing the synchroniser, hold counter and btn_hit pulse generation. Everything else stays in reset_sequencer.

Test Plan:
- All tests use GRACE_CYCLES=8, BTN_HOLD_CYCLES=16, FLUSH_TIMEOUT=10, WDT_CYCLES=32.
- sw_req pulse, flush_ack raised 3 cycles into FLUSH → pending at +1, flush_req at +9, nreset_out low 1 cycle after ack; cause=1.
- sw_req, then sw_cancel 4 cycles later → back to IDLE, cause=0, nreset_out stays 1 over 100 cycles.
- btn_n low for 15 cycles then released → no request. btn_n low for 40 cycles → exactly one request, cause=2, and no second trigger until release.
- sw_req and btn_hit in the same cycle → cause=2. Watchdog expiring during ARMED → cause=3, grace reloaded, a later sw_cancel is ignored.
- flush_ack tied 0 → RESET reached exactly 10 cycles after FLUSH entry.
- rst asserted while in RESET → nreset_out=1, pending=0 asynchronously. With the macro undefined, wdt_en=1 for 100 cycles with no kick → stays IDLE.
